// File: rtl/risc_pkg.sv
// Shared definitions for the Simple RISC CPU: opcode encodings (also used by
// the ALU), sequencer phase encodings and default widths.
package risc_pkg;

    localparam int unsigned DEF_OPCODE_W = 3;
    localparam int unsigned DEF_PHASE_W  = 3;

    // Opcode encodings
    localparam logic [DEF_OPCODE_W-1:0] HLT = 3'b000;
    localparam logic [DEF_OPCODE_W-1:0] SKZ = 3'b001;
    localparam logic [DEF_OPCODE_W-1:0] ADD = 3'b010;
    localparam logic [DEF_OPCODE_W-1:0] AND = 3'b011;
    localparam logic [DEF_OPCODE_W-1:0] XOR = 3'b100;
    localparam logic [DEF_OPCODE_W-1:0] LDA = 3'b101;
    localparam logic [DEF_OPCODE_W-1:0] STO = 3'b110;
    localparam logic [DEF_OPCODE_W-1:0] JMP = 3'b111;

    // Sequencer phase encodings
    localparam logic [DEF_PHASE_W-1:0] INST_ADDR  = 3'd0;
    localparam logic [DEF_PHASE_W-1:0] INST_FETCH = 3'd1;
    localparam logic [DEF_PHASE_W-1:0] INST_LOAD  = 3'd2;
    localparam logic [DEF_PHASE_W-1:0] IDLE       = 3'd3;
    localparam logic [DEF_PHASE_W-1:0] OP_ADDR    = 3'd4;
    localparam logic [DEF_PHASE_W-1:0] OP_FETCH   = 3'd5;
    localparam logic [DEF_PHASE_W-1:0] ALU_OP     = 3'd6;
    localparam logic [DEF_PHASE_W-1:0] STORE      = 3'd7;

endpackage

// File: rtl/risc_controller.sv
// Instruction sequencer for the Simple RISC CPU. An 8-phase counter steps each
// instruction through fetch/decode/operand/execute/store; control strobes are
// decoded combinationally from phase, opcode and the ALU zero flag.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   en       - phase-advance enable (0 = stall)
//   opcode   - IR opcode
//   is_zero  - ALU/accumulator zero flag (used by SKZ)
//   sel      - address mux select (1 = PC, 0 = IR operand)
//   rd       - memory read enable
//   ld_ir    - IR load strobe
//   inc_pc   - PC increment strobe
//   ld_pc    - PC load strobe
//   ld_ac    - accumulator load strobe
//   wr       - memory write strobe
//   data_e   - ALU drives data bus
//   halt     - CPU halted
//   phase    - current phase
module risc_controller
    import risc_pkg::*;
#(
    parameter int unsigned OPCODE_W = DEF_OPCODE_W,
    parameter int unsigned PHASE_W  = DEF_PHASE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                is_zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                wr,
    output logic                data_e,
    output logic                halt,
    output logic [PHASE_W-1:0]  phase
);

    logic halted;
    logic alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= '0;
            halted <= 1'b0;
        end else if (en && !halted) begin
            phase <= phase + PHASE_W'(1);
            // HLT freezes the counter on phase 5, after the PC has stepped past it
            if (phase == OP_ADDR && opcode == HLT)
                halted <= 1'b1;
        end
    end

    assign alu_op = (opcode == ADD) || (opcode == AND) ||
                    (opcode == XOR) || (opcode == LDA);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == SKZ) && is_zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: ;
            endcase
        end
        // Stalled: level signals hold, one-shot strobes are suppressed so
        // nothing is repeated on resume.
        if (!en) begin
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
        end
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Instruction sequencer for the Simple RISC CPU. It sits directly upstream of the ALU and accumulator.
- An 8-phase FSM steps each instruction through the phases fetch, decode, operand fetch, execute and store.
- It decodes the 3-bit opcode from the instruction register and emits the per-phase control strobes.
- These strobes drive the address mux, memory, IR, PC, accumulator and the ALU-to-bus driver. The ALU's is_zero flag is fed back for SKZ.

Parameters:
- OPCODE_W, 3: opcode width; must match the ALU opcode width.
- PHASE_W, 3: phase counter width, giving 8 phases.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: phase-advance enable; 0 stalls the sequencer.
- opcode, input, OPCODE_W: IR opcode; HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- is_zero, input, 1: ALU/accumulator zero flag.
- sel, output, 1: address mux select; 1 = PC, 0 = IR operand address.
- rd, output, 1: memory read enable.
- ld_ir, output, 1: instruction register load strobe.
- inc_pc, output, 1: PC increment strobe.
- ld_pc, output, 1: PC load strobe (JMP).
- ld_ac, output, 1: accumulator load strobe.
- wr, output, 1: memory write strobe.
- data_e, output, 1: ALU/accumulator drives the data bus.
- halt, output, 1: CPU halted.
- phase, output, PHASE_W: current phase, for debug and bench.

Behaviour:
- State:
  - phase register, 0..7; wraps 7->0.
  - halted flag, 1 bit.
- Reset (async, rst=1):
  - phase=0 and halted=0 immediately.
  - Resulting outputs: sel=1; rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt all 0; phase=0.
  - Reset mid-instruction aborts the instruction; no strobe fires in the reset cycle.
- Phase advance: on each rising clk with en=1 and halted=0, phase <= phase+1. Otherwise phase holds.
- Output decoding:
  - Outputs are combinational from phase, opcode and is_zero.
  - ALUOP means opcode in {ADD, AND, XOR, LDA}.
  - Every signal not listed for a phase is 0 in that phase.
- Per-phase outputs:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && is_zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Latency: one instruction every 8 enabled cycles. A new instruction always starts at phase 0.
- Halt:
  - At the rising edge that ends phase 4 with opcode==HLT and en=1, halted<=1.
  - While halted: phase frozen at 5, halt=1, all other outputs 0, sel=0.
  - The PC has already been incremented past HLT in phase 4.
  - Only rst clears halted.
- Stall (en=0):
  - phase holds.
  - Level outputs sel, rd and data_e keep their phase values.
  - Strobes ld_ir, inc_pc, ld_pc, ld_ac and wr are forced to 0, so no action is repeated.
  - halt keeps its value.
- is_zero is sampled only in phase 6 and only for SKZ. It is ignored in all other phases and opcodes.
- opcode is don't-care in phases 0-3, where the IR is still loading.
- en and rst asserted together: rst wins.

Decomposition:
- Shared package risc_pkg:
  - opcode localparams HLT..JMP, shared with the ALU;
  - phase encodings INST_ADDR..STORE;
  - OPCODE_W and PHASE_W defaults.
- No sub-module: the phase counter plus decode fits one module.

Test Plan:
- Reset and fetch: rst pulse, then 4 cycles with en=1 -> phase 0,1,2,3; sel=1 throughout; rd=1 from phase 1; ld_ir=1 in phases 2-3; every other strobe 0.
- ADD: opcode=010, 8 cycles -> phase 4 inc_pc=1; phase 5 rd=1; phase 7 ld_ac=1; wr, ld_pc and data_e never 1; phase wraps to 0.
- SKZ: opcode=001 with is_zero=1 -> phase 6 inc_pc=1. With is_zero=0 -> phase 6 inc_pc=0. inc_pc also =1 in phase 4 in both cases.
- STO: opcode=110 -> data_e=1 in phases 6-7, wr=1 in phase 7 only. JMP: opcode=111 -> ld_pc=1 in phases 6-7, ld_ac never 1.
- HLT: opcode=000 -> phase 4 halt=1 and inc_pc=1. Afterwards phase stays 5, halt=1 and all other outputs 0 for 20 cycles. rst returns phase=0, halt=0.
- Stall and reset: en=0 held 3 cycles in phase 2 -> phase stays 2, rd=1, ld_ir=0; en=1 resumes at phase 3. rst asserted asynchronously mid-phase 6 -> outputs drop to reset values without waiting for clk.
